// File: rtl/regs_wb_arbiter.sv
// Round-robin writeback arbiter sharing the register-file write port between
// requester A (ALU) and B (load). Optional forwarding ports under REGS_WB_BYPASS_EN.
module regs_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Hold,
  input  logic             A_Valid,
  input  logic [4:0]       A_Addr,
  input  logic [31:0]      A_Data,
  output logic             A_Ready,
  input  logic             B_Valid,
  input  logic [4:0]       B_Addr,
  input  logic [31:0]      B_Data,
  output logic             B_Ready,
  output logic             Write_Reg,
  output logic [4:0]       W_Addr,
  output logic [31:0]      W_Data,
  output logic [CNT_W-1:0] Wr_Count
`ifdef REGS_WB_BYPASS_EN
  ,
  input  logic [4:0]       R_Addr_A,
  input  logic [4:0]       R_Addr_B,
  output logic             Fwd_Hit_A,
  output logic             Fwd_Hit_B,
  output logic [31:0]      Fwd_Data_A,
  output logic [31:0]      Fwd_Data_B
`endif
);

  logic             last_b;
  logic             grant_a_p0;
  logic             grant_b_p0;
  logic             xfer_p0;
  logic [4:0]       addr_p0;
  logic signed [31:0] data_p0;

  logic             vld_p1;
  logic [4:0]       addr_p1;
  logic signed [31:0] data_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Stage p0: combinational grant and write-source select
  always_comb begin
    grant_a_p0 = 1'b0;
    grant_b_p0 = 1'b0;
    if (!Reset && !Hold) begin
      grant_a_p0 = A_Valid && (!B_Valid || last_b);
      grant_b_p0 = B_Valid && (!A_Valid || !last_b);
    end
  end

  assign xfer_p0 = grant_a_p0 | grant_b_p0;
  assign addr_p0 = grant_b_p0 ? B_Addr : A_Addr;
  assign data_p0 = grant_b_p0 ? B_Data : A_Data;

  assign A_Ready = grant_a_p0;
  assign B_Ready = grant_b_p0;

  // Stage p1: registered write port; $0 transfers are accepted but dropped
  always_ff @(posedge CLK) begin
    if (Reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      cnt_p1  <= '0;
      last_b  <= 1'b1;
    end else begin
      vld_p1 <= 1'b0;
      if (xfer_p0) begin
        last_b <= grant_b_p0;
        if (addr_p0 != 5'd0) begin
          vld_p1  <= 1'b1;
          addr_p1 <= addr_p0;
          data_p1 <= data_p0;
          cnt_p1  <= cnt_p1 + CNT_W'(1);
        end
      end
    end
  end

  assign Write_Reg = vld_p1;
  assign W_Addr    = addr_p1;
  assign W_Data    = data_p1;
  assign Wr_Count  = cnt_p1;

`ifdef REGS_WB_BYPASS_EN
  // Forward the in-flight write so readers see it before regs commits it
  assign Fwd_Hit_A  = vld_p1 && (addr_p1 == R_Addr_A) && (R_Addr_A != 5'd0);
  assign Fwd_Hit_B  = vld_p1 && (addr_p1 == R_Addr_B) && (R_Addr_B != 5'd0);
  assign Fwd_Data_A = Fwd_Hit_A ? data_p1 : 32'd0;
  assign Fwd_Data_B = Fwd_Hit_B ? data_p1 : 32'd0;
`endif

endmodule
